// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: unbuffered ALU port 0, 2-deep FIFO for port 1, anti-starvation force.
// Grant in cycle N appears on the registered write port in cycle N+1; port 1 backpressures when the FIFO is full.
module regfile_wb_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        p0_valid_i,
    input  logic [4:0]  p0_addr_i,
    input  logic [31:0] p0_data_i,
    output logic        p0_ready_o,
    input  logic        p1_valid_i,
    input  logic [4:0]  p1_addr_i,
    input  logic [31:0] p1_data_i,
    output logic        p1_ready_o,
    input  logic [4:0]  rs_addr_i,
    input  logic [4:0]  rt_addr_i,
    output logic        rs_busy_o,
    output logic        rt_busy_o,
    output logic        RegWrite_o,
    output logic [4:0]  RDaddr_o,
    output logic [31:0] RDdata_o
);

    localparam int SW = (STARVE_MAX < 4) ? 2 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [1:0]    count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [4:0]    a0_q, a0_d, a1_q, a1_d;
    logic [31:0]   d0_q, d0_d, d1_q, d1_d;
    logic          wr_q, wr_d;
    logic          wr_p1_q, wr_p1_d;
    logic [4:0]    rd_addr_q, rd_addr_d;
    logic [31:0]   rd_data_q, rd_data_d;

    logic fifo_ne, force_p1, push, gnt_p0, gnt_p1, wr_idx;

    assign fifo_ne    = (count_q != 2'd0);
    assign force_p1   = (starve_q == STARVE_LIM) && fifo_ne;
    assign p1_ready_o = (count_q < 2'd2);
    assign p0_ready_o = p0_valid_i && !force_p1;
    assign push       = p1_valid_i && p1_ready_o;
    assign gnt_p0     = p0_valid_i && !force_p1;
    assign gnt_p1     = fifo_ne && !gnt_p0;
    // Entry 0 is always the head; a push lands behind whatever survives this cycle's pop.
    assign wr_idx     = (count_q == 2'd1) && !gnt_p1;

    always_comb begin
        a0_d      = a0_q;
        d0_d      = d0_q;
        a1_d      = a1_q;
        d1_d      = d1_q;
        count_d   = count_q + {1'b0, push} - {1'b0, gnt_p1};
        starve_d  = '0;
        wr_d      = 1'b0;
        wr_p1_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;

        if (gnt_p1) begin
            a0_d = a1_q;
            d0_d = d1_q;
        end
        if (push) begin
            if (wr_idx) begin
                a1_d = p1_addr_i;
                d1_d = p1_data_i;
            end else begin
                a0_d = p1_addr_i;
                d0_d = p1_data_i;
            end
        end

        if (gnt_p0 && fifo_ne) begin
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
        end

        if (gnt_p0) begin
            rd_addr_d = p0_addr_i;
            rd_data_d = p0_data_i;
            wr_d      = (p0_addr_i != 5'd0);
        end else if (gnt_p1) begin
            rd_addr_d = a0_q;
            rd_data_d = d0_q;
            wr_d      = (a0_q != 5'd0);
            wr_p1_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q   <= '0;
            starve_q  <= '0;
            a0_q      <= '0;
            d0_q      <= '0;
            a1_q      <= '0;
            d1_q      <= '0;
            wr_q      <= 1'b0;
            wr_p1_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            count_q   <= count_d;
            starve_q  <= starve_d;
            a0_q      <= a0_d;
            d0_q      <= d0_d;
            a1_q      <= a1_d;
            d1_q      <= d1_d;
            wr_q      <= wr_d;
            wr_p1_q   <= wr_p1_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign RegWrite_o = wr_q;
    assign RDaddr_o   = rd_addr_q;
    assign RDdata_o   = rd_data_q;

    // A port-1 write stays a hazard until its register-file write cycle has completed.
    assign rs_busy_o = (rs_addr_i != 5'd0) &&
                       ((fifo_ne && (a0_q == rs_addr_i)) ||
                        ((count_q == 2'd2) && (a1_q == rs_addr_i)) ||
                        (wr_q && wr_p1_q && (rd_addr_q == rs_addr_i)));
    assign rt_busy_o = (rt_addr_i != 5'd0) &&
                       ((fifo_ne && (a0_q == rt_addr_i)) ||
                        ((count_q == 2'd2) && (a1_q == rt_addr_i)) ||
                        (wr_q && wr_p1_q && (rd_addr_q == rt_addr_i)));

endmodule
